// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-I subset core with one shared req/ready memory port and a 32x32 register file.
// Executes add/sub/and/or/slt, lw, sw, beq, addi and j; any other encoding halts the core.
module multicycle_datapath #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retired,
    output logic              halt,
    output logic [31:0]       result_reg
);

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StBranch   = 4'd2;
    localparam logic [3:0] StRExec    = 4'd3;
    localparam logic [3:0] StAddrExec = 4'd4;
    localparam logic [3:0] StMemRd    = 4'd5;
    localparam logic [3:0] StMemWr    = 4'd6;
    localparam logic [3:0] StRWb      = 4'd7;
    localparam logic [3:0] StIWb      = 4'd8;
    localparam logic [3:0] StLwWb     = 4'd9;
    localparam logic [3:0] StHalt     = 4'd10;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       alu_out_q, alu_out_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       rf_q [32];

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic [31:0]       imm_sext, pc_ext, branch_tgt, jump_tgt;
    logic              funct_ok, is_legal;
    logic [ADDR_W-1:0] addr_sel;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    // Targets are formed at 32 bits and truncated, so narrow ADDR_W needs no special casing.
    // In DECODE pc_q already holds PC+4.
    assign pc_ext     = 32'(pc_q);
    assign branch_tgt = pc_ext + {imm_sext[29:0], 2'b00};
    assign jump_tgt   = {pc_ext[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        case (funct)
            FnAdd, FnSub, FnAnd, FnOr, FnSlt: funct_ok = 1'b1;
            default:                          funct_ok = 1'b0;
        endcase
        case (opcode)
            OpRType:                          is_legal = funct_ok;
            OpLw, OpSw, OpBeq, OpAddi, OpJ:   is_legal = 1'b1;
            default:                          is_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out_q;

        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(32'd4);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d       = rf_q[rs];
                b_d       = rf_q[rt];
                alu_out_d = branch_tgt;
                if (!is_legal) begin
                    state_d = StHalt;
                end else begin
                    case (opcode)
                        OpJ: begin
                            pc_d    = jump_tgt[ADDR_W-1:0];
                            state_d = StFetch;
                        end
                        OpBeq:   state_d = StBranch;
                        OpRType: state_d = StRExec;
                        default: state_d = StAddrExec;
                    endcase
                end
            end
            StBranch: begin
                if (a_q == b_q) pc_d = alu_out_q[ADDR_W-1:0];
                state_d = StFetch;
            end
            StRExec: begin
                case (funct)
                    FnAdd:   alu_out_d = a_q + b_q;
                    FnSub:   alu_out_d = a_q - b_q;
                    FnAnd:   alu_out_d = a_q & b_q;
                    FnOr:    alu_out_d = a_q | b_q;
                    default: alu_out_d = {31'b0, $signed(a_q) < $signed(b_q)};
                endcase
                state_d = StRWb;
            end
            StAddrExec: begin
                alu_out_d = a_q + imm_sext;
                case (opcode)
                    OpAddi:  state_d = StIWb;
                    OpLw:    state_d = StMemRd;
                    default: state_d = StMemWr;
                endcase
            end
            StMemRd: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = StLwWb;
                end
            end
            StMemWr: begin
                if (mem_ready) state_d = StFetch;
            end
            StRWb: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                state_d  = StFetch;
            end
            StIWb: begin
                rf_we   = 1'b1;
                state_d = StFetch;
            end
            StLwWb: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                state_d  = StFetch;
            end
            default: state_d = StHalt;
        endcase

        result_d = (rf_we && rf_waddr != 5'd0) ? rf_wdata : result_q;
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = pc_q;
        retired  = 1'b0;
        case (state_q)
            StFetch:  mem_req = 1'b1;
            StMemRd: begin
                mem_req  = 1'b1;
                addr_sel = alu_out_q[ADDR_W-1:0];
            end
            StMemWr: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = alu_out_q[ADDR_W-1:0];
                retired  = mem_ready;
            end
            StDecode:                       retired = is_legal && (opcode == OpJ);
            StBranch, StRWb, StIWb, StLwWb: retired = 1'b1;
            default: ;
        endcase
        // Reset forces FETCH asynchronously; gate the request so it drops in the same cycle.
        if (Reset) begin
            mem_req = 1'b0;
            retired = 1'b0;
        end
    end

    assign mem_addr   = {addr_sel[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = b_q;
    assign pc_out     = pc_q;
    assign halt       = (state_q == StHalt);
    assign result_reg = result_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            result_q  <= result_d;
        end
    end

    // r0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: ISA-level reference model checked on every retirement,
// handshake stability and alignment checked every cycle, plus directed literal expectations.
module tb_multicycle_datapath;

    localparam int unsigned    AW     = 32;
    localparam logic [AW-1:0]  RPC    = '0;
    localparam logic [31:0]    HALT_W = 32'hFC000000;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          mem_req, mem_we, mem_ready, retired, halt;
    logic [AW-1:0] mem_addr, pc_out;
    logic [31:0]   mem_wdata, mem_rdata, result_reg;

    int            wait_n = 0;
    int            wcnt = 0;
    logic [31:0]   tb_mem [256];

    int            nchk = 0;
    int            nerr = 0;

    logic [31:0]   m_mem [256];
    logic [31:0]   m_rf [32];
    logic [31:0]   m_pc, m_res;
    logic [31:0]   pc_hist[$];
    logic [31:0]   res_hist[$];
    int            lat_hist[$];

    multicycle_datapath #(
        .ADDR_W   (AW),
        .RESET_PC (RPC)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .pc_out     (pc_out),
        .retired    (retired),
        .halt       (halt),
        .result_reg (result_reg)
    );

    always #5 CLK = ~CLK;

    // Memory: ready rises after wait_n stalled cycles of an outstanding request.
    assign mem_ready = mem_req && (wcnt >= wait_n);
    assign mem_rdata = tb_mem[mem_addr[9:2]];

    always @(posedge CLK) begin
        if (Reset || !mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_j(int t);
        return {6'b000010, 26'(t)};
    endfunction

    function automatic logic m_illegal(logic [31:0] ins);
        case (ins[31:26])
            6'b000000: return !(ins[5:0] inside {6'b100000, 6'b100010, 6'b100100,
                                                 6'b100101, 6'b101010});
            6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void m_write(logic [4:0] r, logic [31:0] v);
        if (r != 5'd0) begin
            m_rf[r] = v;
            m_res   = v;
        end
    endfunction

    // Executes the instruction at m_pc; returns expected cycle count or -1 if illegal.
    function automatic int model_step();
        logic [31:0] ins, a, b, imm, ea, nxt;
        ins = m_mem[m_pc[9:2]];
        a   = m_rf[ins[25:21]];
        b   = m_rf[ins[20:16]];
        imm = {{16{ins[15]}}, ins[15:0]};
        ea  = a + imm;
        nxt = m_pc + 32'd4;
        if (m_illegal(ins)) return -1;
        case (ins[31:26])
            6'b000000: begin
                case (ins[5:0])
                    6'b100000: m_write(ins[15:11], a + b);
                    6'b100010: m_write(ins[15:11], a - b);
                    6'b100100: m_write(ins[15:11], a & b);
                    6'b100101: m_write(ins[15:11], a | b);
                    default:   m_write(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                endcase
                m_pc = nxt;
                return 4 + wait_n;
            end
            6'b001000: begin
                m_write(ins[20:16], ea);
                m_pc = nxt;
                return 4 + wait_n;
            end
            6'b100011: begin
                m_write(ins[20:16], m_mem[ea[9:2]]);
                m_pc = nxt;
                return 5 + 2 * wait_n;
            end
            6'b101011: begin
                m_mem[ea[9:2]] = b;
                m_pc = nxt;
                return 4 + 2 * wait_n;
            end
            6'b000100: begin
                m_pc = (a == b) ? nxt + (imm << 2) : nxt;
                return 3 + wait_n;
            end
            default: begin
                m_pc = {nxt[31:28], ins[25:0], 2'b00};
                return 2 + wait_n;
            end
        endcase
    endfunction

    function automatic void model_reset();
        m_pc  = RPC;
        m_res = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        pc_hist.delete();
        res_hist.delete();
        lat_hist.delete();
    endfunction

    // Compare process: runs on every falling edge, away from the active edge.
    int          cnt = 0;
    int          lat;
    bit          pend = 0, hseen = 0, pwait = 0;
    logic [AW-1:0] paddr;
    logic        pwe;
    logic [31:0] pwdata;

    always @(negedge CLK) begin
        if (Reset) begin
            cnt   = 0;
            pend  = 0;
            hseen = 0;
            pwait = 0;
        end else begin
            cnt++;
            if (pend) begin
                check("pc after retire", pc_out, m_pc);
                check("result_reg after retire", result_reg, m_res);
                pc_hist.push_back(pc_out);
                res_hist.push_back(result_reg);
                pend = 0;
            end
            if (pwait) begin
                check("req held while waiting", {31'b0, mem_req}, 32'd1);
                check("addr held while waiting", mem_addr, paddr);
                check("we held while waiting", {31'b0, mem_we}, {31'b0, pwe});
                if (pwe) check("wdata held while waiting", mem_wdata, pwdata);
            end
            if (mem_req) check("addr aligned", {30'b0, mem_addr[1:0]}, 32'd0);
            if (mem_req && mem_we && mem_ready) tb_mem[mem_addr[9:2]] = mem_wdata;
            if (retired) begin
                lat = model_step();
                if (lat < 0) check("retire of illegal instr", 32'd1, 32'd0);
                check("instr latency", 32'(cnt), 32'(lat));
                lat_hist.push_back(cnt);
                cnt  = 0;
                pend = 1;
            end
            if (halt && !hseen) begin
                hseen = 1;
                check("halt on illegal", {31'b0, m_illegal(m_mem[m_pc[9:2]])}, 32'd1);
                check("halt latency", 32'(cnt), 32'(3 + wait_n));
            end else if (hseen) begin
                check("halt sticky", {31'b0, halt}, 32'd1);
                check("no req while halted", {31'b0, mem_req}, 32'd0);
            end
            pwait  = mem_req && !mem_ready;
            paddr  = mem_addr;
            pwe    = mem_we;
            pwdata = mem_wdata;
        end
    end

    task automatic begin_test(int w);
        Reset  = 1'b1;
        wait_n = w;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = '0;
            m_mem[i]  = '0;
        end
        model_reset();
    endtask

    task automatic put(logic [31:0] addr, logic [31:0] w);
        tb_mem[addr[9:2]] = w;
        m_mem[addr[9:2]]  = w;
    endtask

    task automatic release_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    task automatic run_to_halt(int bound);
        int n = 0;
        while (!halt && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (!halt) check("halt reached in time", 32'd0, 32'd1);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state
        begin_test(0);
        #1;
        check("reset mem_req", {31'b0, mem_req}, 32'd0);
        check("reset pc_out", pc_out, RPC);
        check("reset result_reg", result_reg, 32'd0);
        check("reset halt", {31'b0, halt}, 32'd0);
        check("reset retired", {31'b0, retired}, 32'd0);

        // addi/addi/add chain, zero-wait
        put(32'h00, enc_i(6'b001000, 0, 1, 5));
        put(32'h04, enc_i(6'b001000, 1, 2, -7));
        put(32'h08, enc_r(1, 2, 3, 6'b100000));
        release_reset();
        #1 check("first fetch req", {31'b0, mem_req}, 32'd1);
        check("first fetch addr", mem_addr, RPC);
        run_to_halt(200);
        check("t1 retire count", 32'(res_hist.size()), 32'd3);
        check("t1 res0", res_hist[0], 32'd5);
        check("t1 res1", res_hist[1], 32'hFFFFFFFE);
        check("t1 res2", res_hist[2], 32'd3);
        for (int i = 0; i < 3; i++) check("t1 latency", 32'(lat_hist[i]), 32'd4);

        // sw/lw with three wait states per access
        begin_test(3);
        put(32'h00, enc_i(6'b001000, 0, 1, 5));
        put(32'h04, enc_j(32'h10));
        put(32'h40, enc_i(6'b101011, 0, 1, 8));
        put(32'h44, enc_i(6'b100011, 0, 4, 8));
        release_reset();
        run_to_halt(400);
        check("t2 stored word", tb_mem[2], 32'd5);
        check("t2 sw latency", 32'(lat_hist[2]), 32'd10);
        check("t2 lw latency", 32'(lat_hist[3]), 32'd11);
        check("t2 r4 result", result_reg, 32'd5);

        // j and taken beq
        begin_test(0);
        put(32'h000, enc_j(32'h40));
        put(32'h100, enc_i(6'b001000, 0, 1, 5));
        put(32'h104, enc_j(4));
        put(32'h010, enc_i(6'b000100, 1, 1, 2));
        release_reset();
        run_to_halt(200);
        check("t3 j target", pc_hist[0], 32'h100);
        check("t3 j latency", 32'(lat_hist[0]), 32'd2);
        check("t3 beq taken pc", pc_hist[3], 32'h1C);
        check("t3 beq latency", 32'(lat_hist[3]), 32'd3);

        // beq not taken
        begin_test(0);
        put(32'h00, enc_i(6'b001000, 0, 1, 5));
        put(32'h04, enc_i(6'b001000, 0, 2, 7));
        put(32'h08, enc_j(4));
        put(32'h10, enc_i(6'b000100, 1, 2, 2));
        release_reset();
        run_to_halt(200);
        check("t4 beq untaken pc", pc_hist[3], 32'h14);

        // write to r0 discarded; opcode 111111 halts
        begin_test(0);
        put(32'h00, enc_i(6'b001000, 0, 1, 5));
        put(32'h04, enc_r(1, 1, 0, 6'b100000));
        put(32'h08, enc_i(6'b001000, 0, 6, 1));
        put(32'h0C, HALT_W);
        release_reset();
        run_to_halt(200);
        check("t5 r0 write keeps result", res_hist[1], 32'd5);
        check("t5 r0 reads zero", res_hist[2], 32'd1);
        check("t5 halt", {31'b0, halt}, 32'd1);
        check("t5 no req", {31'b0, mem_req}, 32'd0);
        check("t5 pc after illegal fetch", pc_out, 32'h10);

        // ALU ops, one wait state, illegal R-type funct at end
        begin_test(1);
        put(32'h00, enc_i(6'b001000, 0, 1, -3));
        put(32'h04, enc_i(6'b001000, 0, 2, 6));
        put(32'h08, enc_r(2, 1, 3, 6'b100010));
        put(32'h0C, enc_r(1, 2, 4, 6'b100100));
        put(32'h10, enc_r(1, 2, 5, 6'b100101));
        put(32'h14, enc_r(1, 2, 6, 6'b101010));
        put(32'h18, enc_r(2, 1, 7, 6'b101010));
        put(32'h1C, enc_r(1, 2, 8, 6'b100001));
        release_reset();
        run_to_halt(300);
        check("t6 sub", res_hist[2], 32'd9);
        check("t6 and", res_hist[3], 32'd4);
        check("t6 or", res_hist[4], 32'hFFFFFFFF);
        check("t6 slt true", res_hist[5], 32'd1);
        check("t6 slt false", res_hist[6], 32'd0);
        check("t6 halt on bad funct", {31'b0, halt}, 32'd1);

        // Reset in the middle of a lw wait
        begin_test(3);
        put(32'h00, enc_i(6'b001000, 0, 1, 5));
        put(32'h04, enc_i(6'b100011, 0, 2, 32'h20));
        put(32'h20, 32'h00001234);
        release_reset();
        n = 0;
        while (!(mem_req && !mem_we && mem_addr == 32'h20) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("t7 reached MEM_RD", {31'b0, mem_req && !mem_we && mem_addr == 32'h20}, 32'd1);
        Reset = 1'b1;
        #1;
        check("t7 req drops on reset", {31'b0, mem_req}, 32'd0);
        check("t7 result cleared", result_reg, 32'd0);
        check("t7 pc reset", pc_out, RPC);
        model_reset();
        release_reset();
        #1;
        check("t7 refetch req", {31'b0, mem_req}, 32'd1);
        check("t7 refetch addr", mem_addr, RPC);
        check("t7 result after release", result_reg, 32'd0);
        run_to_halt(300);
        check("t7 lw value", result_reg, 32'h00001234);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
